// File: rtl/pong_pkg.sv
// Shared Pong definitions: screen size, ball geometry, ball FSM state codes
// and the paddle hit-window test used by the ball engine.
package pong_pkg;

   localparam int COORD_W = 11;
   localparam int SCORE_W = 4;

   localparam int H_RES = 640;
   localparam int V_RES = 480;

   localparam logic [COORD_W-1:0] CENTRE_X = COORD_W'(H_RES / 2);
   localparam logic [COORD_W-1:0] CENTRE_Y = COORD_W'(V_RES / 2);

   // Paddle half-height plus ball half-size, in 12 bits so that the window
   // sums below cannot wrap.
   localparam logic [COORD_W:0]   HIT_HALF = 12'd64;
   localparam logic [COORD_W-1:0] P1_HIT_X = 11'd34;
   localparam logic [COORD_W-1:0] P2_HIT_X = 11'd606;
   localparam logic [COORD_W-1:0] Y_MIN    = 11'd4;
   localparam logic [COORD_W-1:0] Y_MAX    = 11'd475;
   localparam logic [COORD_W-1:0] GOAL_L   = 11'd4;
   localparam logic [COORD_W-1:0] GOAL_R   = 11'd636;

   // Ball FSM state codes
   localparam logic [1:0] ST_SERVE = 2'd0;
   localparam logic [1:0] ST_PLAY  = 2'd1;
   localparam logic [1:0] ST_OVER  = 2'd2;

   // True when the ball centre lies within HIT_HALF of the paddle centre.
   // Both sides are widened to 12 bits and only additions are used, so a
   // paddle near the top edge never produces an underflowed bound.
   function automatic logic in_window(input logic [COORD_W-1:0] pad_y,
                                      input logic [COORD_W-1:0] ball_y);
      logic [COORD_W:0] pad_w;
      logic [COORD_W:0] ball_w;
      pad_w  = {1'b0, pad_y};
      ball_w = {1'b0, ball_y};
      return (pad_w <= ball_w + HIT_HALF) && (ball_w <= pad_w + HIT_HALF);
   endfunction

endpackage

// File: rtl/move_tick_gen.sv
// Move-tick generator: divides clk by DIV while en is high.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   en       : counter advances only while high
//   tick     : one-cycle strobe when en=1 and the counter is at DIV-1
module move_tick_gen #(
   parameter int DIV = 131072
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      tick  = en && (cnt_q == LAST);
      cnt_d = cnt_q;
      if (en) begin
         cnt_d = tick ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/ball_engine.sv
// Pong ball engine: moves the ball one pixel per axis per move tick, bounces
// it off the top/bottom walls and the two paddle faces, detects goals, keeps
// score and stops the game when a player reaches WIN_SCORE.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   en                 : run enable; low freezes everything
//   p1_y, p2_y         : paddle centre y, sampled on move ticks only
//   ball_x, ball_y     : registered ball centre
//   p1_score, p2_score : registered scores
//   p1_point, p2_point : one-cycle pulse on the tick a point is scored
//   game_over          : high once either score reaches WIN_SCORE
module ball_engine
   import pong_pkg::*;
#(
   parameter int TICK_DIV    = 131072,
   parameter int SERVE_TICKS = 64,
   parameter int WIN_SCORE   = 9
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [COORD_W-1:0] p1_y,
   input  logic [COORD_W-1:0] p2_y,
   output logic [COORD_W-1:0] ball_x,
   output logic [COORD_W-1:0] ball_y,
   output logic [SCORE_W-1:0] p1_score,
   output logic [SCORE_W-1:0] p2_score,
   output logic               p1_point,
   output logic               p2_point,
   output logic               game_over
);

   localparam int SW = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;
   localparam logic [SW-1:0]      SERVE_LAST = SW'(SERVE_TICKS - 1);
   localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);

   logic tick;

   move_tick_gen #(.DIV(TICK_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .tick (tick)
   );

   // Direction flags: 1 means +1 (right / down), 0 means -1.
   logic [1:0]         state_q,     state_d;
   logic [COORD_W-1:0] x_q,         x_d;
   logic [COORD_W-1:0] y_q,         y_d;
   logic               dx_pos_q,    dx_pos_d;
   logic               dy_pos_q,    dy_pos_d;
   logic               serve_dy_q,  serve_dy_d;   // dy used by the latest serve
   logic [SW-1:0]      serve_cnt_q, serve_cnt_d;
   logic [SCORE_W-1:0] p1_score_q,  p1_score_d;
   logic [SCORE_W-1:0] p2_score_q,  p2_score_d;
   logic               p1_point_q,  p1_point_d;
   logic               p2_point_q,  p2_point_d;
   logic               game_over_q, game_over_d;

   logic y_flip, dy_new, p1_hit, p2_hit, goal_p1, goal_p2;

   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      dx_pos_d    = dx_pos_q;
      dy_pos_d    = dy_pos_q;
      serve_dy_d  = serve_dy_q;
      serve_cnt_d = serve_cnt_q;
      p1_score_d  = p1_score_q;
      p2_score_d  = p2_score_q;
      p1_point_d  = 1'b0;
      p2_point_d  = 1'b0;

      // Wall and paddle tests both look at the registered position, so a
      // corner contact flips both directions on the same tick.
      y_flip  = (!dy_pos_q && (y_q <= Y_MIN)) || (dy_pos_q && (y_q >= Y_MAX));
      dy_new  = dy_pos_q ^ y_flip;
      p1_hit  = !dx_pos_q && (x_q == P1_HIT_X) && in_window(p1_y, y_q);
      p2_hit  =  dx_pos_q && (x_q == P2_HIT_X) && in_window(p2_y, y_q);
      goal_p2 = !dx_pos_q && (x_q == GOAL_L);
      goal_p1 =  dx_pos_q && (x_q == GOAL_R);

      if (tick) begin
         case (state_q)
            ST_SERVE: begin
               if (serve_cnt_q == SERVE_LAST) begin
                  state_d     = ST_PLAY;
                  serve_cnt_d = '0;
               end else begin
                  serve_cnt_d = serve_cnt_q + 1'b1;
               end
            end
            ST_PLAY: begin
               if (goal_p1 || goal_p2) begin
                  // Recentre and serve toward the player who conceded, with
                  // vertical direction alternating from serve to serve.
                  x_d        = CENTRE_X;
                  y_d        = CENTRE_Y;
                  dx_pos_d   = goal_p1;
                  serve_dy_d = ~serve_dy_q;
                  dy_pos_d   = ~serve_dy_q;
                  state_d    = ST_SERVE;
                  if (goal_p1) begin
                     p1_score_d = p1_score_q + 4'd1;
                     p1_point_d = 1'b1;
                     if (p1_score_d == WIN) state_d = ST_OVER;
                  end else begin
                     p2_score_d = p2_score_q + 4'd1;
                     p2_point_d = 1'b1;
                     if (p2_score_d == WIN) state_d = ST_OVER;
                  end
               end else begin
                  dy_pos_d = dy_new;
                  y_d      = dy_new ? y_q + 11'd1 : y_q - 11'd1;
                  if (p1_hit) begin
                     dx_pos_d = 1'b1;
                     x_d      = x_q + 11'd1;
                  end else if (p2_hit) begin
                     dx_pos_d = 1'b0;
                     x_d      = x_q - 11'd1;
                  end else begin
                     x_d = dx_pos_q ? x_q + 11'd1 : x_q - 11'd1;
                  end
               end
            end
            ST_OVER: begin
               // Held until reset.
            end
            default: state_d = ST_SERVE;
         endcase
      end

      game_over_d = (state_d == ST_OVER);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_SERVE;
         x_q         <= CENTRE_X;
         y_q         <= CENTRE_Y;
         dx_pos_q    <= 1'b1;
         dy_pos_q    <= 1'b1;
         serve_dy_q  <= 1'b1;
         serve_cnt_q <= '0;
         p1_score_q  <= '0;
         p2_score_q  <= '0;
         p1_point_q  <= 1'b0;
         p2_point_q  <= 1'b0;
         game_over_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         dx_pos_q    <= dx_pos_d;
         dy_pos_q    <= dy_pos_d;
         serve_dy_q  <= serve_dy_d;
         serve_cnt_q <= serve_cnt_d;
         p1_score_q  <= p1_score_d;
         p2_score_q  <= p2_score_d;
         p1_point_q  <= p1_point_d;
         p2_point_q  <= p2_point_d;
         game_over_q <= game_over_d;
      end
   end

   assign ball_x    = x_q;
   assign ball_y    = y_q;
   assign p1_score  = p1_score_q;
   assign p2_score  = p2_score_q;
   assign p1_point  = p1_point_q;
   assign p2_point  = p2_point_q;
   assign game_over = game_over_q;

endmodule

// File: tb/tb_ball_engine.sv
// Bench for ball_engine with TICK_DIV=4, SERVE_TICKS=2: a move tick lands on
// every 4th enabled clock edge after reset release, so tick N is applied on
// edge 4*N. Expected ball positions are worked out by hand from the
// bounce geometry (serve from (320,240), two serve ticks, then one pixel per
// axis per tick).
module tb_ball_engine;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [10:0] p1_y;
   logic [10:0] p2_y;
   logic [10:0] ball_x;
   logic [10:0] ball_y;
   logic [3:0]  p1_score;
   logic [3:0]  p2_score;
   logic        p1_point;
   logic        p2_point;
   logic        game_over;

   ball_engine #(.TICK_DIV(4), .SERVE_TICKS(2), .WIN_SCORE(9)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .p1_y      (p1_y),
      .p2_y      (p2_y),
      .ball_x    (ball_x),
      .ball_y    (ball_y),
      .p1_score  (p1_score),
      .p2_score  (p2_score),
      .p1_point  (p1_point),
      .p2_point  (p2_point),
      .game_over (game_over)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;   // enabled edges since reset release

   typedef struct {
      int tick;
      int x;
      int y;
      int s1;
      int s2;
      int pt1;
      int pt2;
   } vec_t;

   vec_t vecs[15];

   // ---------------- driver / checker tasks ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      if (n > 0) begin
         repeat (n) @(posedge clk);
         #1;
         cyc += n;
      end
   endtask

   task automatic to_tick(input int m);
      step(4 * m - cyc);
   endtask

   task automatic chk_ball(input string tag, input int x, input int y);
      chk({tag, ".x"}, 32'(ball_x), x);
      chk({tag, ".y"}, 32'(ball_y), y);
   endtask

   task automatic chk_status(input string tag, input int s1, input int s2,
                             input int pt1, input int pt2, input int go);
      chk({tag, ".p1_score"},  32'(p1_score),  s1);
      chk({tag, ".p2_score"},  32'(p2_score),  s2);
      chk({tag, ".p1_point"},  32'(p1_point),  pt1);
      chk({tag, ".p2_point"},  32'(p2_point),  pt2);
      chk({tag, ".game_over"}, 32'(game_over), go);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b0;
      cyc = 0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst  = 1'b1;
      en   = 1'b1;
      p1_y = 11'd220;
      p2_y = 11'd418;

      // Rally: bottom wall, P2 hit, top wall, P1 hit at the window edge
      // (p1_y=220, ball y=156), bottom wall, P2 miss, P1 goal.
      vecs[0]  = '{0,    320, 240, 0, 0, 0, 0};
      vecs[1]  = '{2,    320, 240, 0, 0, 0, 0};
      vecs[2]  = '{3,    321, 241, 0, 0, 0, 0};
      vecs[3]  = '{237,  555, 475, 0, 0, 0, 0};
      vecs[4]  = '{238,  556, 474, 0, 0, 0, 0};
      vecs[5]  = '{288,  606, 424, 0, 0, 0, 0};
      vecs[6]  = '{289,  605, 423, 0, 0, 0, 0};
      vecs[7]  = '{290,  604, 422, 0, 0, 0, 0};
      vecs[8]  = '{708,  186,   4, 0, 0, 0, 0};
      vecs[9]  = '{709,  185,   5, 0, 0, 0, 0};
      vecs[10] = '{860,   34, 156, 0, 0, 0, 0};
      vecs[11] = '{861,   35, 157, 0, 0, 0, 0};
      vecs[12] = '{1179, 353, 475, 0, 0, 0, 0};
      vecs[13] = '{1462, 636, 192, 0, 0, 0, 0};
      vecs[14] = '{1463, 320, 240, 1, 0, 1, 0};

      do_reset();
      for (int i = 0; i < 15; i++) begin
         to_tick(vecs[i].tick);
         chk_ball($sformatf("vec%0d", i), vecs[i].x, vecs[i].y);
         chk_status($sformatf("vec%0d", i), vecs[i].s1, vecs[i].s2,
                    vecs[i].pt1, vecs[i].pt2, 0);
      end

      // Point pulse lasts one cycle; next serve heads right (toward P2,
      // who conceded) with dy inverted to -1.
      step(1);
      chk("p1_point_width", 32'(p1_point), 0);
      to_tick(1465);
      chk_ball("serve2_hold", 320, 240);
      to_tick(1466);
      chk_ball("serve2_move", 321, 239);

      // Freeze for 101 cycles: ball and tick phase must both hold.
      en = 1'b0;
      repeat (101) @(posedge clk);
      #1;
      chk_ball("frozen", 321, 239);
      chk_status("frozen", 1, 0, 0, 0, 0);
      en = 1'b1;
      step(3);
      chk_ball("resume_pre", 321, 239);
      to_tick(1467);
      chk_ball("resume_tick", 322, 238);

      // Corner contact at the P2 face on the bottom wall, inside the
      // window (p2_y=418): both directions flip on the same tick.
      force u_dut.x_q      = 11'd606;
      force u_dut.y_q      = 11'd475;
      force u_dut.dx_pos_q = 1'b1;
      force u_dut.dy_pos_q = 1'b1;
      #1;
      release u_dut.x_q;
      release u_dut.y_q;
      release u_dut.dx_pos_q;
      release u_dut.dy_pos_q;
      to_tick(1468);
      chk_ball("corner", 605, 474);
      to_tick(1469);
      chk_ball("corner_next", 604, 473);

      // Asynchronous reset mid-play takes effect before the next edge.
      #2;
      rst = 1'b1;
      #1;
      chk_ball("async_rst", 320, 240);
      chk_status("async_rst", 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b0;
      cyc = 0;
      to_tick(2);
      chk_ball("rst_serve", 320, 240);
      to_tick(3);
      chk_ball("rst_move", 321, 241);

      // P1 paddle one pixel outside the window (221 vs y=156): ball passes
      // to GOAL_L and P2 scores; serve heads left with dy=-1.
      p1_y = 11'd221;
      to_tick(890);
      chk_ball("p2goal_pre", 4, 186);
      chk_status("p2goal_pre", 0, 0, 0, 0, 0);
      to_tick(891);
      chk_ball("p2goal", 320, 240);
      chk_status("p2goal", 0, 1, 0, 1, 0);
      to_tick(894);
      chk_ball("p2goal_serve", 319, 239);

      // Nine straight P1 goals with P2 missing every time.
      p1_y = 11'd240;
      p2_y = 11'd240;
      do_reset();
      for (int j = 1; j <= 9; j++) begin
         to_tick(319 * j - 1);
         chk_ball($sformatf("win%0d_pre", j), 636, (j % 2 == 1) ? 394 : 84);
         chk_status($sformatf("win%0d_pre", j), j - 1, 0, 0, 0, 0);
         to_tick(319 * j);
         chk_ball($sformatf("win%0d_goal", j), 320, 240);
         chk_status($sformatf("win%0d_goal", j), j, 0, 1, 0, (j == 9) ? 1 : 0);
         step(1);
         chk($sformatf("win%0d_pulse_end", j), 32'(p1_point), 0);
      end
      to_tick(319 * 9 + 300);
      chk_ball("over_hold", 320, 240);
      chk_status("over_hold", 9, 0, 0, 0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
